// File: rtl/atan_pkg.sv
// Shared constants and types for the arctangent pipeline.
// oct_o bit positions are also used by the downstream angle reconstruction stage.
package atan_pkg;

   localparam int ATAN_DATA_W = 8;

   localparam int OCT_SWAP = 0;
   localparam int OCT_XNEG = 1;
   localparam int OCT_YNEG = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } atan_state_e;

endpackage

// File: rtl/atan_div_seq.sv
// Sequential restoring divider producing a DATA_W-bit fraction of num/den, MSB first.
// One quotient bit per step; done flags the final step so the caller can capture quot_nxt.
module atan_div_seq #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [DATA_W-1:0] num_i,
   input  logic [DATA_W-1:0] den_i,
   output logic              done,
   output logic [DATA_W-1:0] quot_nxt
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [DATA_W-1:0] den_q;
   logic [DATA_W-1:0] quot_q;
   logic [DATA_W:0]   rem_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [DATA_W:0]   rem_sh;
   logic [DATA_W:0]   rem_nxt;
   logic              q_bit;

   always_comb begin
      rem_sh   = {rem_q[DATA_W-1:0], 1'b0};
      q_bit    = (rem_sh >= {1'b0, den_q});
      rem_nxt  = q_bit ? (rem_sh - {1'b0, den_q}) : rem_sh;
      quot_nxt = {quot_q[DATA_W-2:0], q_bit};
      done     = (cnt_q == '0);
   end

   // num <= den always holds here, so the integer quotient bits of num*2^DATA_W/den
   // are zero and the remainder after shifting in num's own bits is num itself.
   // Loading that remainder directly lets the DATA_W steps shift in only the zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         den_q  <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
      end else if (load) begin
         den_q  <= den_i;
         quot_q <= '0;
         rem_q  <= {1'b0, num_i};
         cnt_q  <= CNT_W'(DATA_W - 1);
      end else if (step) begin
         rem_q  <= rem_nxt;
         quot_q <= quot_nxt;
         if (cnt_q != '0)
            cnt_q <= cnt_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/atan_arg_reduce.sv
// Folds (x, y) into the first octant and computes min/max as an unsigned Q0.8 ratio.
//   state | meaning
//   IDLE  | ready, waiting for val_i
//   DIV   | DATA_W restoring-divider iterations
//   DONE  | val_o strobe, ratio_o/oct_o valid
module atan_arg_reduce
   import atan_pkg::*;
#(
   parameter int DATA_W = ATAN_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              val_i,
   input  logic [DATA_W-1:0] x_i,
   input  logic [DATA_W-1:0] y_i,
   output logic              rdy_o,
   output logic              val_o,
   output logic [DATA_W-1:0] ratio_o,
   output logic [2:0]        oct_o
);

   atan_state_e state_q, state_d;

   logic [DATA_W-1:0] ax, ay, num, den;
   logic              x_neg, y_neg, swap;

   logic              div_load, div_step, div_done;
   logic [DATA_W-1:0] div_quot_nxt;

   logic [2:0]        oct_q;
   logic              zero_q, eq_q;

   // Two's-complement magnitude; the most negative value maps to 2^(DATA_W-1) unsigned.
   always_comb begin
      x_neg = x_i[DATA_W-1];
      y_neg = y_i[DATA_W-1];
      ax    = x_neg ? (~x_i + DATA_W'(1)) : x_i;
      ay    = y_neg ? (~y_i + DATA_W'(1)) : y_i;
      swap  = (ay > ax);
      num   = swap ? ax : ay;
      den   = swap ? ay : ax;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (val_i) state_d = DIV;
         DIV:     if (div_done) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rdy_o    = (state_q == IDLE);
      val_o    = (state_q == DONE);
      div_load = (state_q == IDLE) && val_i;
      div_step = (state_q == DIV);
   end

   atan_div_seq #(.DATA_W(DATA_W)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (div_load),
      .step     (div_step),
      .num_i    (num),
      .den_i    (den),
      .done     (div_done),
      .quot_nxt (div_quot_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oct_q  <= '0;
         zero_q <= 1'b0;
         eq_q   <= 1'b0;
      end else if (div_load) begin
         oct_q[OCT_SWAP] <= swap;
         oct_q[OCT_XNEG] <= x_neg;
         oct_q[OCT_YNEG] <= y_neg;
         zero_q          <= (den == '0);
         eq_q            <= (num == den);
      end
   end

   // Results land on the DIV->DONE edge; 1.0 saturates to all-ones and 0/0 reads as 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ratio_o <= '0;
         oct_o   <= '0;
      end else if (div_step && div_done) begin
         oct_o <= oct_q;
         if (zero_q)
            ratio_o <= '0;
         else if (eq_q)
            ratio_o <= '1;
         else
            ratio_o <= div_quot_nxt;
      end
   end

endmodule

// File: tb/tb_atan_arg_reduce.sv
// Scoreboard bench for atan_arg_reduce: directed vectors push expectations, a monitor checks val_o.
module tb_atan_arg_reduce;
   import atan_pkg::*;

   localparam int W = ATAN_DATA_W;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         val_i = 1'b0;
   logic [W-1:0] x_i = '0;
   logic [W-1:0] y_i = '0;
   logic         rdy_o, val_o;
   logic [W-1:0] ratio_o;
   logic [2:0]   oct_o;

   typedef struct {
      logic [7:0] ratio;
      logic [2:0] oct;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   acc = 0;

   atan_arg_reduce #(.DATA_W(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .val_i   (val_i),
      .x_i     (x_i),
      .y_i     (y_i),
      .rdy_o   (rdy_o),
      .val_o   (val_o),
      .ratio_o (ratio_o),
      .oct_o   (oct_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input int c);
      exp_t e;
      int xs, ys, ax, ay, num, den;
      xs = int'($signed(x));
      ys = int'($signed(y));
      ax = (xs < 0) ? -xs : xs;
      ay = (ys < 0) ? -ys : ys;
      num = (ay > ax) ? ax : ay;
      den = (ay > ax) ? ay : ax;
      if (den == 0)        e.ratio = 8'h00;
      else if (num == den) e.ratio = 8'hFF;
      else                 e.ratio = 8'((num * 256) / den);
      e.oct = {ys < 0, xs < 0, ay > ax};
      e.cyc = c;
      return e;
   endfunction

   // Monitor: every val_o strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && val_o) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_val_o: got ratio %0h oct %0b with nothing outstanding", ratio_o, oct_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("ratio", 32'(ratio_o), 32'(e.ratio));
            chk("oct", 32'(oct_o), 32'(e.oct));
            chk("latency", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [7:0] r, input logic [2:0] o);
      exp_t e;
      int t;
      t = 0;
      @(negedge clk);
      while (!rdy_o && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!rdy_o) begin
         n_chk++;
         n_fail++;
         $display("FAIL rdy_timeout: got rdy_o %0b expected 1", rdy_o);
      end
      x_i = x;
      y_i = y;
      val_i = 1'b1;
      e.ratio = r;
      e.oct = o;
      e.cyc = cyc + 9;
      sb.push_back(e);
      @(negedge clk);
      val_i = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk("drain_outstanding", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the end of the test");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      chk("reset_rdy", 32'(rdy_o), 32'd1);
      chk("reset_val", 32'(val_o), 32'd0);
      chk("reset_ratio", 32'(ratio_o), 32'd0);
      chk("reset_oct", 32'(oct_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      send(8'd100, 8'd50, 8'h80, 3'b000);
      @(negedge clk);
      chk("busy_rdy_low", 32'(rdy_o), 32'd0);
      drain();
      send(8'h80, 8'd127, 8'hFE, 3'b010);
      drain();
      send(8'd3, 8'hF9, 8'h6D, 3'b101);
      drain();
      send(8'd0, 8'd0, 8'h00, 3'b000);
      drain();
      send(8'hFB, 8'd5, 8'hFF, 3'b010);
      drain();
      send(8'hFF, 8'h80, 8'h02, 3'b111);
      drain();
      chk("ratio_holds", 32'(ratio_o), 32'h02);

      // val_i held high with new operands every cycle.
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         x_i = 8'($urandom);
         y_i = 8'($urandom);
         val_i = 1'b1;
         if (rdy_o) begin
            sb.push_back(model(x_i, y_i, cyc + 9));
            acc++;
            chk("accept_spacing", 32'(i % 10), 32'd0);
         end
      end
      @(negedge clk);
      val_i = 1'b0;
      chk("stream_accepts", 32'(acc), 32'd4);
      drain();

      // Abort in the 4th DIV cycle.
      send(8'd100, 8'd50, 8'h80, 3'b000);
      repeat (3) @(negedge clk);
      sb.delete();
      rst_n = 1'b0;
      #1;
      chk("abort_rdy", 32'(rdy_o), 32'd1);
      chk("abort_val", 32'(val_o), 32'd0);
      chk("abort_ratio", 32'(ratio_o), 32'd0);
      chk("abort_oct", 32'(oct_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      send(8'd100, 8'd50, 8'h80, 3'b000);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
